// File: rtl/pcileech_ft601_emu_pkg.sv
// Shared types and constants for the FT601 device-side emulator.
package pcileech_ft601_emu_pkg;

    // Bus phase as seen from the FT601 pins.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TURN  = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } ft601_emu_state_t;

    // Byte enables the device drives while it owns the bus.
    localparam logic [3:0] FT601_BE_ALL = 4'hF;

    // Width of the saturating underrun/overflow counters.
    localparam int CNT_WIDTH = 16;

endpackage

// File: rtl/pcileech_ft601_emu_fifo.sv
// Synchronous first-word-fall-through FIFO used for both emulator directions.
// The caller only issues legal operations: push when not full (or when full
// together with a pop) and pop only when not empty. The head and the entry
// behind it are both visible so the caller can preload the following word
// while a pop is in progress.
module pcileech_ft601_emu_fifo #(
    parameter int WIDTH      = 36,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wr_data,
    output logic [WIDTH-1:0]      head,
    output logic [WIDTH-1:0]      head_next,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;

    // Storage array; contents need no reset because occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head      = mem[rd_ptr];
    assign head_next = mem[rd_ptr + DEPTH_LOG2'(1)];
    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);

endmodule

// File: rtl/pcileech_ft601_emu.sv
// FT601 245-synchronous-FIFO device emulator: serves host words to the FPGA
// controller over RXF_n/OE_n/RD_n and captures FPGA writes over TXE_n/WR_n.
// Optional protocol checker: define PCILEECH_FT601_EMU_CHECK_EN to build it;
// otherwise proto_err is tied low.
// ft601_rxf_n doubles as "ft601_data_out does not hold a valid word": a pushed
// word reaches the bus register one edge after it lands in the FIFO, and reads
// are only honoured once it is visible there.
module pcileech_ft601_emu
    import pcileech_ft601_emu_pkg::*;
#(
    parameter int FIFO_DEPTH_LOG2 = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          host_tx_data,
    input  logic                 host_tx_valid,
    output logic                 host_tx_ready,
    output logic [35:0]          host_rx_data,
    output logic                 host_rx_valid,
    input  logic                 host_rx_ready,
    input  logic [31:0]          ft601_data_in,
    input  logic [3:0]           ft601_be_in,
    output logic [31:0]          ft601_data_out,
    output logic [3:0]           ft601_be_out,
    output logic                 ft601_data_oe,
    output logic                 ft601_rxf_n,
    output logic                 ft601_txe_n,
    input  logic                 ft601_rd_n,
    input  logic                 ft601_oe_n,
    input  logic                 ft601_wr_n,
    input  logic                 ft601_siwu_n,
    output logic [CNT_WIDTH-1:0] cnt_underrun,
    output logic [CNT_WIDTH-1:0] cnt_overflow,
    output logic                 proto_err
);
    localparam int CW = FIFO_DEPTH_LOG2 + 1;
    localparam logic [FIFO_DEPTH_LOG2:0] FULL_COUNT = CW'(1 << FIFO_DEPTH_LOG2);
    localparam logic [FIFO_DEPTH_LOG2:0] ONE_COUNT  = CW'(1);

    logic                     started;
    ft601_emu_state_t         state;
    ft601_emu_state_t         state_next;

    logic                     tx_push;
    logic                     tx_pop;
    logic [31:0]              tx_head;
    logic [31:0]              tx_head_next;
    logic [FIFO_DEPTH_LOG2:0] tx_count;
    logic [FIFO_DEPTH_LOG2:0] tx_count_next;
    logic                     tx_full;
    logic                     tx_empty;

    logic                     rx_push;
    logic                     rx_pop;
    logic [35:0]              rx_head_next;
    logic [FIFO_DEPTH_LOG2:0] rx_count;
    logic [FIFO_DEPTH_LOG2:0] rx_count_next;
    logic                     rx_full;
    logic                     rx_empty;

    logic                     read_req;
    logic                     write_req;
    logic                     underrun_ev;
    logic                     overflow_ev;
    logic                     bus_show;
    logic [31:0]              bus_data_next;

    pcileech_ft601_emu_fifo #(
        .WIDTH      (32),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_push),
        .pop       (tx_pop),
        .wr_data   (host_tx_data),
        .head      (tx_head),
        .head_next (tx_head_next),
        .count     (tx_count),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    pcileech_ft601_emu_fifo #(
        .WIDTH      (36),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rx_push),
        .pop       (rx_pop),
        .wr_data   ({ft601_be_in, ft601_data_in}),
        .head      (host_rx_data),
        .head_next (rx_head_next),
        .count     (rx_count),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    // Stream handshakes, bus requests and the next bus word to present.
    always_comb begin
        tx_push       = host_tx_valid && host_tx_ready;
        rx_pop        = host_rx_valid && host_rx_ready;
        read_req      = started && !ft601_oe_n && !ft601_rd_n;
        write_req     = started && !ft601_wr_n;
        tx_pop        = read_req && !ft601_rxf_n;
        underrun_ev   = read_req && ft601_rxf_n;
        rx_push       = write_req && (!rx_full || rx_pop);
        overflow_ev   = write_req && rx_full && !rx_pop;
        tx_count_next = tx_count + CW'(tx_push) - CW'(tx_pop);
        rx_count_next = rx_count + CW'(rx_push) - CW'(rx_pop);
        bus_show      = 1'b0;
        bus_data_next = ft601_data_out;
        if (tx_pop) begin
            if (tx_count > ONE_COUNT) begin
                bus_show      = 1'b1;
                bus_data_next = tx_head_next;
            end
        end else if (!tx_empty) begin
            bus_show      = 1'b1;
            bus_data_next = tx_head;
        end
    end

    // Registered flags, bus data and saturating error counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            started        <= 1'b0;
            ft601_data_out <= '0;
            ft601_rxf_n    <= 1'b1;
            ft601_txe_n    <= 1'b1;
            host_tx_ready  <= 1'b0;
            host_rx_valid  <= 1'b0;
            cnt_underrun   <= '0;
            cnt_overflow   <= '0;
        end else begin
            started        <= 1'b1;
            ft601_data_out <= bus_data_next;
            ft601_rxf_n    <= !bus_show;
            ft601_txe_n    <= !started || (rx_count_next == FULL_COUNT);
            host_tx_ready  <= started && (tx_count_next != FULL_COUNT);
            host_rx_valid  <= started && (rx_count_next != '0);
            if (underrun_ev && (cnt_underrun != '1)) begin
                cnt_underrun <= cnt_underrun + CNT_WIDTH'(1);
            end
            if (overflow_ev && (cnt_overflow != '1)) begin
                cnt_overflow <= cnt_overflow + CNT_WIDTH'(1);
            end
        end
    end

    // Bus phase register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bus phase transitions; output enable takes priority over write in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!ft601_oe_n) begin
                    state_next = TURN;
                end else if (!ft601_wr_n) begin
                    state_next = WRITE;
                end
            end
            TURN: begin
                if (ft601_oe_n) begin
                    state_next = IDLE;
                end else if (!ft601_rd_n) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (ft601_oe_n) begin
                    state_next = IDLE;
                end
            end
            WRITE: begin
                if (ft601_wr_n) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ft601_data_oe = !ft601_oe_n;
    assign ft601_be_out  = FT601_BE_ALL;

    logic unused_fifo_status;
    assign unused_fifo_status = ^{tx_full, rx_empty, rx_head_next};

`ifdef PCILEECH_FT601_EMU_CHECK_EN
    logic prev_oe_n;

    // Sticky protocol checker; only a reset clears proto_err.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            proto_err <= 1'b0;
            prev_oe_n <= 1'b1;
        end else begin
            prev_oe_n <= ft601_oe_n;
            if (started && ((!ft601_wr_n && !ft601_oe_n) ||
                            (!ft601_rd_n && prev_oe_n) ||
                            (!ft601_wr_n && ((state == TURN) || (state == READ))) ||
                            !ft601_siwu_n)) begin
                proto_err <= 1'b1;
            end
        end
    end
`else
    logic unused_checker_inputs;
    assign unused_checker_inputs = ^{ft601_siwu_n, state};
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_pcileech_ft601_emu.sv
// Directed self-checking bench for pcileech_ft601_emu (4-word FIFOs).
module tb_pcileech_ft601_emu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] host_tx_data;
    logic        host_tx_valid;
    logic        host_tx_ready;
    logic [35:0] host_rx_data;
    logic        host_rx_valid;
    logic        host_rx_ready;
    logic [31:0] ft601_data_in;
    logic [3:0]  ft601_be_in;
    logic [31:0] ft601_data_out;
    logic [3:0]  ft601_be_out;
    logic        ft601_data_oe;
    logic        ft601_rxf_n;
    logic        ft601_txe_n;
    logic        ft601_rd_n;
    logic        ft601_oe_n;
    logic        ft601_wr_n;
    logic        ft601_siwu_n;
    logic [15:0] cnt_underrun;
    logic [15:0] cnt_overflow;
    logic        proto_err;

    int compared   = 0;
    int mismatched = 0;

`ifdef PCILEECH_FT601_EMU_CHECK_EN
    localparam logic CHECK_ON = 1'b1;
`else
    localparam logic CHECK_ON = 1'b0;
`endif

    pcileech_ft601_emu #(.FIFO_DEPTH_LOG2(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .host_tx_data   (host_tx_data),
        .host_tx_valid  (host_tx_valid),
        .host_tx_ready  (host_tx_ready),
        .host_rx_data   (host_rx_data),
        .host_rx_valid  (host_rx_valid),
        .host_rx_ready  (host_rx_ready),
        .ft601_data_in  (ft601_data_in),
        .ft601_be_in    (ft601_be_in),
        .ft601_data_out (ft601_data_out),
        .ft601_be_out   (ft601_be_out),
        .ft601_data_oe  (ft601_data_oe),
        .ft601_rxf_n    (ft601_rxf_n),
        .ft601_txe_n    (ft601_txe_n),
        .ft601_rd_n     (ft601_rd_n),
        .ft601_oe_n     (ft601_oe_n),
        .ft601_wr_n     (ft601_wr_n),
        .ft601_siwu_n   (ft601_siwu_n),
        .cnt_underrun   (cnt_underrun),
        .cnt_overflow   (cnt_overflow),
        .proto_err      (proto_err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hostPush(input logic [31:0] word);
        host_tx_data  = word;
        host_tx_valid = 1'b1;
        tick();
        host_tx_valid = 1'b0;
    endtask

    task automatic fpgaWrite(input logic [3:0] be, input logic [31:0] word);
        ft601_be_in   = be;
        ft601_data_in = word;
        ft601_wr_n    = 1'b0;
        tick();
        ft601_wr_n    = 1'b1;
    endtask

    task automatic hostPop(input string tag, input logic [35:0] expected);
        checkOutput({tag, "_valid"}, 64'(host_rx_valid), 64'd1);
        checkOutput({tag, "_data"}, 64'(host_rx_data), 64'(expected));
        host_rx_ready = 1'b1;
        tick();
        host_rx_ready = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        host_tx_data  = '0;
        host_tx_valid = 1'b0;
        host_rx_ready = 1'b0;
        ft601_data_in = '0;
        ft601_be_in   = '0;
        ft601_rd_n    = 1'b1;
        ft601_oe_n    = 1'b1;
        ft601_wr_n    = 1'b1;
        ft601_siwu_n  = 1'b1;
        tick();
        tick();

        // Reset values
        checkOutput("rst_rxf_n", 64'(ft601_rxf_n), 64'd1);
        checkOutput("rst_txe_n", 64'(ft601_txe_n), 64'd1);
        checkOutput("rst_data_oe", 64'(ft601_data_oe), 64'd0);
        checkOutput("rst_data_out", 64'(ft601_data_out), 64'd0);
        checkOutput("rst_tx_ready", 64'(host_tx_ready), 64'd0);
        checkOutput("rst_rx_valid", 64'(host_rx_valid), 64'd0);
        checkOutput("rst_underrun", 64'(cnt_underrun), 64'd0);
        checkOutput("rst_overflow", 64'(cnt_overflow), 64'd0);
        checkOutput("rst_proto_err", 64'(proto_err), 64'd0);
        checkOutput("be_out", 64'(ft601_be_out), 64'hF);

        rst_n = 1'b1;
        tick();
        checkOutput("rel0_txe_n", 64'(ft601_txe_n), 64'd1);
        checkOutput("rel0_tx_ready", 64'(host_tx_ready), 64'd0);
        tick();
        checkOutput("rel1_txe_n", 64'(ft601_txe_n), 64'd0);
        checkOutput("rel1_tx_ready", 64'(host_tx_ready), 64'd1);

        // Single read
        hostPush(32'hDEADBEEF);
        checkOutput("rd_rxf_n_push", 64'(ft601_rxf_n), 64'd1);
        tick();
        checkOutput("rd_rxf_n_vis", 64'(ft601_rxf_n), 64'd0);
        checkOutput("rd_data_vis", 64'(ft601_data_out), 64'hDEADBEEF);
        ft601_oe_n = 1'b0;
        #1;
        checkOutput("rd_data_oe", 64'(ft601_data_oe), 64'd1);
        tick();
        ft601_rd_n = 1'b0;
        tick();
        ft601_rd_n = 1'b1;
        checkOutput("rd_rxf_n_after", 64'(ft601_rxf_n), 64'd1);
        checkOutput("rd_data_after", 64'(ft601_data_out), 64'hDEADBEEF);
        ft601_oe_n = 1'b1;
        tick();
        checkOutput("rd_underrun", 64'(cnt_underrun), 64'd0);

        // Burst write of four words, then drain
        for (int i = 1; i <= 4; i++) begin
            fpgaWrite(4'hF, 32'(i));
        end
        checkOutput("bw_txe_n_full", 64'(ft601_txe_n), 64'd1);
        for (int i = 1; i <= 4; i++) begin
            hostPop("bw_pop", {4'hF, 32'(i)});
        end
        checkOutput("bw_rx_empty", 64'(host_rx_valid), 64'd0);
        checkOutput("bw_txe_n_free", 64'(ft601_txe_n), 64'd0);
        checkOutput("bw_overflow", 64'(cnt_overflow), 64'd0);

        // Full boundary: six writes into a four-entry FIFO
        for (int i = 0; i < 6; i++) begin
            fpgaWrite(4'hA, 32'h11 + 32'(i));
            if (i == 2) checkOutput("fb_txe_n_3", 64'(ft601_txe_n), 64'd0);
            if (i == 3) checkOutput("fb_txe_n_4", 64'(ft601_txe_n), 64'd1);
        end
        checkOutput("fb_overflow", 64'(cnt_overflow), 64'd2);
        for (int i = 0; i < 4; i++) begin
            hostPop("fb_pop", {4'hA, 32'h11 + 32'(i)});
        end
        checkOutput("fb_rx_empty", 64'(host_rx_valid), 64'd0);

        // Underrun: one word, read strobe held three cycles
        hostPush(32'hCAFE0001);
        tick();
        ft601_oe_n = 1'b0;
        tick();
        ft601_rd_n = 1'b0;
        tick();
        tick();
        tick();
        ft601_rd_n = 1'b1;
        ft601_oe_n = 1'b1;
        checkOutput("ur_underrun", 64'(cnt_underrun), 64'd2);
        checkOutput("ur_data_hold", 64'(ft601_data_out), 64'hCAFE0001);
        checkOutput("ur_rxf_n", 64'(ft601_rxf_n), 64'd1);
        tick();
        checkOutput("pre_chk_proto_err", 64'(proto_err), 64'd0);

        // Protocol checker: write while output enable asserted
        ft601_oe_n = 1'b0;
        fpgaWrite(4'h3, 32'h77);
        ft601_oe_n = 1'b1;
        checkOutput("chk_proto_err", 64'(proto_err), 64'(CHECK_ON));
        tick();
        tick();
        checkOutput("chk_proto_sticky", 64'(proto_err), 64'(CHECK_ON));
        checkOutput("chk_rx_word", 64'(host_rx_valid), 64'd1);

        // Reset in the middle of a read burst
        hostPush(32'hA0);
        hostPush(32'hA1);
        hostPush(32'hA2);
        tick();
        checkOutput("rb_data_first", 64'(ft601_data_out), 64'hA0);
        ft601_oe_n = 1'b0;
        tick();
        ft601_rd_n = 1'b0;
        tick();
        checkOutput("rb_data_second", 64'(ft601_data_out), 64'hA1);
        rst_n = 1'b0;
        tick();
        checkOutput("rb_rst_rxf_n", 64'(ft601_rxf_n), 64'd1);
        checkOutput("rb_rst_data_out", 64'(ft601_data_out), 64'd0);
        checkOutput("rb_rst_data_oe_on", 64'(ft601_data_oe), 64'd1);
        checkOutput("rb_rst_proto_err", 64'(proto_err), 64'd0);
        checkOutput("rb_rst_underrun", 64'(cnt_underrun), 64'd0);
        checkOutput("rb_rst_rx_valid", 64'(host_rx_valid), 64'd0);
        ft601_rd_n = 1'b1;
        ft601_oe_n = 1'b1;
        #1;
        checkOutput("rb_rst_data_oe_off", 64'(ft601_data_oe), 64'd0);
        rst_n = 1'b1;
        tick();
        tick();
        checkOutput("rb_rel_rxf_n", 64'(ft601_rxf_n), 64'd1);
        checkOutput("rb_rel_rx_valid", 64'(host_rx_valid), 64'd0);
        checkOutput("rb_rel_tx_ready", 64'(host_tx_ready), 64'd1);
        hostPush(32'h55);
        tick();
        checkOutput("rb_fresh_rxf_n", 64'(ft601_rxf_n), 64'd0);
        checkOutput("rb_fresh_data", 64'(ft601_data_out), 64'h55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
